// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of N_STAGES Direct Form I biquads sharing one multiplier-accumulator; one sample in flight, result 6A+B+2 cycles after acceptance.
// Define IIR_SAT_FLAGS_STICKY_EN for latching saturation flags; default build gives per-sample flag pulses aligned with o_valid_out.
module iir_biquad_cascade_tdm #(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_FRAC   = 15,
   parameter int COEFF_WIDTH = 20,
   parameter int COEFF_FRAC  = 18,
   parameter int N_STAGES    = 3,
   parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3,
   localparam int SW         = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid_in,
   output logic                   o_ready_in,
   input  logic [DATA_WIDTH-1:0]  i_data_in,
   input  logic [N_STAGES-1:0]    i_bypass,
   input  logic                   i_coeff_wr_en,
   input  logic [SW-1:0]          i_coeff_stage,
   input  logic [2:0]             i_coeff_addr,
   input  logic [COEFF_WIDTH-1:0] i_coeff_data,
   output logic                   o_coeff_wr_err,
   output logic [DATA_WIDTH-1:0]  o_data_out,
   output logic                   o_valid_out,
   output logic [N_STAGES-1:0]    o_overflow,
   output logic [N_STAGES-1:0]    o_underflow
);

   localparam int PW  = DATA_WIDTH + COEFF_WIDTH;
   // Product carries DATA_FRAC+COEFF_FRAC fraction bits; drop down to DATA_FRAC.
   localparam int SHR = (DATA_FRAC + COEFF_FRAC) - DATA_FRAC;
   localparam logic signed [ACC_WIDTH-1:0]   RND      = ACC_WIDTH'(1) << (SHR - 1);
   localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;
   localparam logic signed [DATA_WIDTH-1:0]  SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0]  SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_WB, S_BYP, S_OUT} state_t;

   state_t                        r_state, w_state_nxt;
   logic [SW-1:0]                 r_sec;
   logic [2:0]                    r_tap;
   logic [N_STAGES-1:0]           r_byp;
   logic signed [DATA_WIDTH-1:0]  r_x_cur;
   logic signed [DATA_WIDTH-1:0]  r_x1 [N_STAGES];
   logic signed [DATA_WIDTH-1:0]  r_x2 [N_STAGES];
   logic signed [DATA_WIDTH-1:0]  r_y1 [N_STAGES];
   logic signed [DATA_WIDTH-1:0]  r_y2 [N_STAGES];
   logic signed [COEFF_WIDTH-1:0] r_coef [N_STAGES][5];
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic [N_STAGES-1:0]           r_ovf, r_unf;
   logic [DATA_WIDTH-1:0]         r_dout;
   logic                          r_vout, r_wr_err;
`ifndef IIR_SAT_FLAGS_STICKY_EN
   logic [N_STAGES-1:0]           r_ovf_pend, r_unf_pend;
`endif

   logic [SW-1:0]                 w_sec_nxt;
   logic                          w_last, w_sub;
   logic signed [DATA_WIDTH-1:0]  w_opd, w_sat;
   logic signed [COEFF_WIDTH-1:0] w_cof;
   logic signed [PW-1:0]          w_opd_ext, w_cof_ext, w_prod;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext, w_rnd, w_shr;
   logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
   logic                          w_pos_sat, w_neg_sat;

   assign w_sec_nxt = r_sec + 1'b1;
   assign w_last    = (r_sec == SW'(N_STAGES - 1));

   // Feedback taps are subtracted rather than negating a1/a2, which could overflow at -2.0.
   always_comb begin
      w_opd = r_x_cur;
      w_cof = r_coef[r_sec][0];
      w_sub = 1'b0;
      case (r_tap)
         3'd1: begin w_opd = r_x1[r_sec]; w_cof = r_coef[r_sec][1]; end
         3'd2: begin w_opd = r_x2[r_sec]; w_cof = r_coef[r_sec][2]; end
         3'd3: begin w_opd = r_y1[r_sec]; w_cof = r_coef[r_sec][3]; w_sub = 1'b1; end
         3'd4: begin w_opd = r_y2[r_sec]; w_cof = r_coef[r_sec][4]; w_sub = 1'b1; end
         default: ;
      endcase
   end

   assign w_opd_ext  = {{COEFF_WIDTH{w_opd[DATA_WIDTH-1]}}, w_opd};
   assign w_cof_ext  = {{DATA_WIDTH{w_cof[COEFF_WIDTH-1]}}, w_cof};
   assign w_prod     = w_opd_ext * w_cof_ext;
   assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};

   assign w_rnd     = r_acc + RND;
   assign w_shr     = w_rnd >>> SHR;
   assign w_hi      = w_shr[ACC_WIDTH-1:DATA_WIDTH-1];
   assign w_pos_sat = ~w_shr[ACC_WIDTH-1] & (|w_hi);
   assign w_neg_sat = w_shr[ACC_WIDTH-1] & ~(&w_hi);
   assign w_sat     = w_pos_sat ? SAT_MAX : (w_neg_sat ? SAT_MIN : w_shr[DATA_WIDTH-1:0]);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_ready_in  = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready_in = 1'b1;
            if (i_valid_in) w_state_nxt = i_bypass[0] ? S_BYP : S_MAC;
         end
         S_MAC: if (r_tap == 3'd4) w_state_nxt = S_WB;
         S_WB, S_BYP: begin
            if (w_last)                w_state_nxt = S_OUT;
            else if (r_byp[w_sec_nxt]) w_state_nxt = S_BYP;
            else                       w_state_nxt = S_MAC;
         end
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sec    <= '0;
         r_tap    <= '0;
         r_byp    <= '0;
         r_x_cur  <= '0;
         r_acc    <= '0;
         r_ovf    <= '0;
         r_unf    <= '0;
         r_dout   <= '0;
         r_vout   <= 1'b0;
         r_wr_err <= 1'b0;
`ifndef IIR_SAT_FLAGS_STICKY_EN
         r_ovf_pend <= '0;
         r_unf_pend <= '0;
`endif
         for (int k = 0; k < N_STAGES; k++) begin
            r_x1[k] <= '0;
            r_x2[k] <= '0;
            r_y1[k] <= '0;
            r_y2[k] <= '0;
            for (int t = 0; t < 5; t++) r_coef[k][t] <= (t == 0) ? COEF_ONE : '0;
         end
      end else begin
         r_vout   <= 1'b0;
         r_wr_err <= 1'b0;
`ifndef IIR_SAT_FLAGS_STICKY_EN
         r_ovf <= '0;
         r_unf <= '0;
`endif
         // Writes land before a same-cycle acceptance is processed, so that sample sees them.
         if (i_coeff_wr_en) begin
            if (r_state == S_IDLE && int'(i_coeff_stage) < N_STAGES) begin
               for (int k = 0; k < N_STAGES; k++)
                  if (int'(i_coeff_stage) == k && i_coeff_addr < 3'd5)
                     r_coef[k][i_coeff_addr] <= i_coeff_data;
            end else begin
               r_wr_err <= 1'b1;
            end
         end
         case (r_state)
            S_IDLE: if (i_valid_in) begin
               r_x_cur <= i_data_in;
               r_byp   <= i_bypass;
               r_sec   <= '0;
`ifndef IIR_SAT_FLAGS_STICKY_EN
               r_ovf_pend <= '0;
               r_unf_pend <= '0;
`endif
            end
            S_MAC: begin
               if (r_tap == 3'd0) r_acc <= w_prod_ext;
               else if (w_sub)    r_acc <= r_acc - w_prod_ext;
               else               r_acc <= r_acc + w_prod_ext;
               r_tap <= (r_tap == 3'd4) ? 3'd0 : r_tap + 3'd1;
            end
            S_WB: begin
               r_tap   <= '0;
               r_x_cur <= w_sat;
               r_sec   <= w_sec_nxt;
               for (int k = 0; k < N_STAGES; k++) begin
                  if (int'(r_sec) == k) begin
                     r_x2[k] <= r_x1[k];
                     r_x1[k] <= r_x_cur;
                     r_y2[k] <= r_y1[k];
                     r_y1[k] <= w_sat;
`ifdef IIR_SAT_FLAGS_STICKY_EN
                     if (w_pos_sat) r_ovf[k] <= 1'b1;
                     if (w_neg_sat) r_unf[k] <= 1'b1;
`else
                     if (w_pos_sat) r_ovf_pend[k] <= 1'b1;
                     if (w_neg_sat) r_unf_pend[k] <= 1'b1;
`endif
                  end
               end
            end
            S_BYP: r_sec <= w_sec_nxt;
            S_OUT: begin
               r_dout <= r_x_cur;
               r_vout <= 1'b1;
`ifndef IIR_SAT_FLAGS_STICKY_EN
               r_ovf <= r_ovf_pend;
               r_unf <= r_unf_pend;
`endif
            end
            default: ;
         endcase
      end
   end

   assign o_data_out     = r_dout;
   assign o_valid_out    = r_vout;
   assign o_coeff_wr_err = r_wr_err;
   assign o_overflow     = r_ovf;
   assign o_underflow    = r_unf;

endmodule
